// File: rtl/lfsr_word_sched_if.sv
// Word handshake between the LFSR word sequencer and its consumer.
// Latency: none, this file holds wires only.
// Backpressure: the consumer drives out_ready; the word holds while out_ready is low.
interface lfsr_word_sched_if #(
  parameter int OUT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_word_sched.sv
// Galois LFSR sequencer that packs serial output bits LSB-first into OUT_W-bit words.
// Latency: OUT_W enabled cycles from the seed edge to the first word, then OUT_W+1 cycles per word.
// Backpressure: a finished word is held with the LFSR frozen until out_ready; seed_load overrides everything.
// Optional build macro LFSR_WORD_CNT_EN adds the word_cnt handshake counter port.
module lfsr_word_sched #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter int                OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed_data,
  lfsr_word_sched_if.master     word,
  output logic                  zero_seed,
`ifdef LFSR_WORD_CNT_EN
  output logic [15:0]           word_cnt,
`endif
  output logic                  busy
);

  localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    S_UNSEEDED = 2'd0,
    S_FILL     = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              zero_seed_q;
  logic              out_valid_c;
  logic              busy_c;
  logic              step;
  logic              last_bit;

  // One Galois step: shift right, fold the taps back in when the outgoing bit is set.
  assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  assign step     = (state_q == S_FILL) && en;
  assign last_bit = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_UNSEEDED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a seed strobe beats the handshake and the fill step in any state.
  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = S_FILL;
    end else begin
      case (state_q)
        S_FILL:  if (en && last_bit) state_d = S_HOLD;
        S_HOLD:  if (word.out_ready) state_d = S_FILL;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs decoded straight from the registered state.
  always_comb begin
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      S_FILL:  busy_c      = 1'b1;
      S_HOLD:  out_valid_c = 1'b1;
      default: begin
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
      end
    endcase
  end

  // Datapath: seeding with zero substitution, LFSR stepping and LSB-first word packing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      zero_seed_q <= 1'b0;
    end else if (seed_load) begin
      // out_data is left alone; the next word overwrites it bit by bit.
      lfsr_q      <= (seed_data == '0) ? LFSR_W'(1) : seed_data;
      zero_seed_q <= (seed_data == '0);
      cnt_q       <= '0;
    end else if (step) begin
      lfsr_q            <= lfsr_nxt;
      out_data_q[cnt_q] <= lfsr_q[0];
      cnt_q             <= last_bit ? '0 : cnt_q + CNT_W'(1);
    end
  end

`ifdef LFSR_WORD_CNT_EN
  // Delivered-word counter; a reseed restarts the count even on a handshake edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
    end else if (seed_load) begin
      word_cnt <= '0;
    end else if (out_valid_c && word.out_ready) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

  assign word.out_valid = out_valid_c;
  assign word.out_data  = out_data_q;
  assign busy           = busy_c;
  assign zero_seed      = zero_seed_q;

endmodule

// File: tb/tb_lfsr_word_sched.sv
// Self-checking bench for lfsr_word_sched: reference LFSR model feeds a word scoreboard.
// Inputs change 1 ns after the rising edge; outputs are sampled there or on the falling edge.
// Build with LFSR_WORD_CNT_EN defined to also exercise the word counter.
module tb_lfsr_word_sched;

  localparam int          OUT_W = 8;
  localparam logic [15:0] TAPS  = 16'hB400;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        seed_load;
  logic [15:0] seed_data;
  logic        zero_seed;
  logic        busy;
`ifdef LFSR_WORD_CNT_EN
  logic [15:0] word_cnt;
`endif

  lfsr_word_sched_if #(.OUT_W(OUT_W)) u_if ();

  lfsr_word_sched #(
    .LFSR_W (16),
    .TAPS   (TAPS),
    .OUT_W  (OUT_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .word      (u_if),
    .zero_seed (zero_seed),
`ifdef LFSR_WORD_CNT_EN
    .word_cnt  (word_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         words_seen = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe a seed for one edge and refill the scoreboard from the reference model.
  task automatic load_seed(input logic [15:0] s);
    logic [15:0] st;
    logic [7:0]  w;
    seed_load = 1'b1;
    seed_data = s;
    exp_q.delete();
    st = (s == 16'h0000) ? 16'h0001 : s;
    for (int i = 0; i < 40; i++) begin
      w = '0;
      for (int k = 0; k < OUT_W; k++) begin
        w[k] = st[0];
        st   = lfsr_step(st);
      end
      exp_q.push_back(w);
    end
    tick();
    seed_load = 1'b0;
  endtask

  task automatic wait_valid(output int n, input int maxc);
    n = 0;
    while (!u_if.out_valid && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_next(output int n, input int maxc);
    n = 0;
    while (u_if.out_valid && n < maxc) begin
      tick();
      n++;
    end
    while (!u_if.out_valid && n < maxc) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard: a handshake that will complete on the next rising edge pops one expected word.
  always @(negedge clk) begin
    if (reset && u_if.out_valid && u_if.out_ready && !seed_load) begin
      if (exp_q.size() > 0) begin
        chk("sb_word", 32'(u_if.out_data), 32'(exp_q.pop_front()));
        words_seen++;
      end else begin
        n_chk++;
        $display("FAIL sb_underflow: got word %0h, scoreboard empty", u_if.out_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic busy_bad;

    reset           = 1'b0;
    en              = 1'b0;
    seed_load       = 1'b0;
    seed_data       = 16'h0000;
    u_if.out_ready  = 1'b0;

    #12;
    chk("rst_valid", 32'(u_if.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(u_if.out_data), 0);
    chk("rst_zero_seed", 32'(zero_seed), 0);
`ifdef LFSR_WORD_CNT_EN
    chk("rst_word_cnt", 32'(word_cnt), 0);
`endif
    tick();
    reset = 1'b1;

    // Unseeded: enable and ready must not start anything.
    en             = 1'b1;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("unseeded_idle", {u_if.out_valid, busy, u_if.out_data}, 0);
    end

    // Seed 1: first word 01 after 8 cycles, second word 68 nine cycles later.
    load_seed(16'h0001);
    chk("zero_seed_clear", 32'(zero_seed), 0);
    wait_valid(n, 50);
    chk("lat_first", n, 8);
    chk("word1", 32'(u_if.out_data), 32'h01);
    wait_next(n, 50);
    chk("lat_second", n, 9);
    chk("word2", 32'(u_if.out_data), 32'h68);
`ifdef LFSR_WORD_CNT_EN
    chk("word_cnt_one", 32'(word_cnt), 1);
`endif

    // Zero seed substitutes 1 and raises the sticky flag (loaded over a pending handshake).
    load_seed(16'h0000);
    chk("zero_seed_set", 32'(zero_seed), 1);
    wait_valid(n, 50);
    chk("lat_zero_seed", n, 8);
    chk("zs_word1", 32'(u_if.out_data), 32'h01);
    wait_next(n, 50);
    chk("zs_word2", 32'(u_if.out_data), 32'h68);
    load_seed(16'h0001);
    chk("zero_seed_reclear", 32'(zero_seed), 0);

    // en toggling every cycle doubles the fill time; busy stays high throughout.
    u_if.out_ready = 1'b0;
    busy_bad       = 1'b0;
    n              = 0;
    while (!u_if.out_valid && n < 60) begin
      en = ~en;
      tick();
      n++;
      if (!u_if.out_valid && !busy) busy_bad = 1'b1;
    end
    chk("lat_en_toggle", n, 16);
    chk("busy_during_fill", 32'(busy_bad), 0);
    chk("toggle_word", 32'(u_if.out_data), 32'h01);

    // Backpressure: word and LFSR held while out_ready is low.
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_data", 32'(u_if.out_data), 32'h01);
      chk("hold_valid", 32'(u_if.out_valid), 1);
    end
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    wait_valid(n, 50);
    chk("after_hold_lat", n, 8);
    chk("after_hold_word", 32'(u_if.out_data), 32'h68);
`ifdef LFSR_WORD_CNT_EN
    chk("word_cnt_after_hold", 32'(word_cnt), 1);
`endif

    // Seed on the same edge as out_ready: the pending word is dropped.
    u_if.out_ready = 1'b1;
    load_seed(16'h0001);
    chk("drop_valid", 32'(u_if.out_valid), 0);
    chk("drop_busy", 32'(busy), 1);
`ifdef LFSR_WORD_CNT_EN
    chk("drop_word_cnt", 32'(word_cnt), 0);
`endif
    wait_valid(n, 50);
    chk("restart_lat", n, 8);
    chk("restart_word", 32'(u_if.out_data), 32'h01);

    // Asynchronous reset between edges, mid-fill after a zero seed.
    load_seed(16'h0000);
    tick();
    tick();
    tick();
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_valid", 32'(u_if.out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_data", 32'(u_if.out_data), 0);
    chk("arst_zero_seed", 32'(zero_seed), 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_idle", {u_if.out_valid, busy}, 0);
    end

    // Arbitrary seed: scoreboard compares the running word stream against the model.
    load_seed(16'hACE1);
    wait_valid(n, 50);
    chk("acel_lat", n, 8);
    for (int i = 0; i < 4; i++) begin
      wait_next(n, 50);
      chk("acel_period", n, 9);
    end
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
